// File: rtl/wisc_pkg.sv
// Shared WISC ISA definitions: opcode constants, decode bundle and decode-stage FSM states.
// Also imported by ALU control, which consumes alu_op/alu_f from the bundle.
package wisc_pkg;

    localparam logic [4:0] OpHalt  = 5'b00000;
    localparam logic [4:0] OpJ     = 5'b00100;
    localparam logic [4:0] OpJr    = 5'b00101;
    localparam logic [4:0] OpJal   = 5'b00110;
    localparam logic [4:0] OpJalr  = 5'b00111;
    localparam logic [4:0] OpXori  = 5'b01010;
    localparam logic [4:0] OpAndni = 5'b01011;
    localparam logic [4:0] OpSt    = 5'b10000;
    localparam logic [4:0] OpLd    = 5'b10001;
    localparam logic [4:0] OpSlbi  = 5'b10010;
    localparam logic [4:0] OpStu   = 5'b10011;
    localparam logic [4:0] OpLbi   = 5'b11000;
    localparam logic [4:0] OpBtr   = 5'b11001;
    localparam logic [4:0] OpAlu1  = 5'b11010;
    localparam logic [4:0] OpAlu2  = 5'b11011;

    // Opcode groups keyed on opcode[4:2].
    localparam logic [2:0] GrpJump   = 3'b001;
    localparam logic [2:0] GrpImmAlu = 3'b010;
    localparam logic [2:0] GrpBranch = 3'b011;
    localparam logic [2:0] GrpMem    = 3'b100;
    localparam logic [2:0] GrpShift  = 3'b101;
    localparam logic [2:0] GrpCmp    = 3'b111;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHalting = 2'd1,
        StHalted  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [1:0]  alu_f;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        logic [15:0] imm;
    } ctrl_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational WISC instruction decoder: one 16-bit instruction word in,
// one control bundle out.
module instr_decode_comb
    import wisc_pkg::*;
(
    input  logic [15:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [4:0] op;
    logic [2:0] grp;
    logic       is_rfmt;
    logic       is_ialu;

    assign op      = instr_i[15:11];
    assign grp     = op[4:2];
    assign is_rfmt = (op == OpAlu1) || (op == OpAlu2) || (grp == GrpCmp);
    assign is_ialu = (grp == GrpImmAlu) || (grp == GrpShift);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = op;
        ctrl_o.alu_f  = instr_i[1:0];
        ctrl_o.rs     = instr_i[10:8];
        ctrl_o.rt     = instr_i[7:5];

        if (is_rfmt) begin
            ctrl_o.rd = instr_i[4:2];
        end else if (is_ialu || (op == OpLd) || (op == OpStu)) begin
            ctrl_o.rd = instr_i[7:5];
        end else if ((op == OpLbi) || (op == OpSlbi)) begin
            ctrl_o.rd = instr_i[10:8];
        end else if ((op == OpJal) || (op == OpJalr)) begin
            ctrl_o.rd = 3'd7;
        end

        ctrl_o.reg_write = is_rfmt || is_ialu || (op == OpLd) || (op == OpStu) ||
                           (op == OpLbi) || (op == OpSlbi) || (op == OpBtr) ||
                           (op == OpJal) || (op == OpJalr);
        ctrl_o.mem_read  = (op == OpLd);
        ctrl_o.mem_write = (op == OpSt) || (op == OpStu);
        ctrl_o.is_branch = (grp == GrpBranch);
        ctrl_o.is_jump   = (grp == GrpJump);

        // Order matters: logical imms and slbi are zero-extended inside sign-extended groups.
        if ((op == OpXori) || (op == OpAndni) || (grp == GrpShift)) begin
            ctrl_o.imm = {11'd0, instr_i[4:0]};
        end else if (op == OpSlbi) begin
            ctrl_o.imm = {8'd0, instr_i[7:0]};
        end else if ((grp == GrpImmAlu) || (grp == GrpMem)) begin
            ctrl_o.imm = {{11{instr_i[4]}}, instr_i[4:0]};
        end else if ((grp == GrpBranch) || (op == OpLbi) || (op == OpJr) || (op == OpJalr)) begin
            ctrl_o.imm = {{8{instr_i[7]}}, instr_i[7:0]};
        end else if ((op == OpJ) || (op == OpJal)) begin
            ctrl_o.imm = {{5{instr_i[10]}}, instr_i[10:0]};
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode pipeline stage: decodes on entry, buffers in a main register plus one skid
// register, and freezes after a HALT has issued downstream.
module instr_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_ALUOp,
    output logic [1:0]  out_ALUF,
    output logic [2:0]  out_rs,
    output logic [2:0]  out_rt,
    output logic [2:0]  out_rd,
    output logic        out_regWrite,
    output logic        out_memRead,
    output logic        out_memWrite,
    output logic        out_isBranch,
    output logic        out_isJump,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic        halted
);
    import wisc_pkg::*;

    ctrl_t        dec_ctrl;
    ctrl_t        main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [15:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    stage_state_e state_q, state_d;
    logic         accept;
    logic         issue;

    instr_decode_comb u_decode (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl)
    );

    assign accept    = in_valid && in_ready_q;
    assign out_valid = main_valid_q && (state_q != StHalted);
    assign issue     = out_valid && out_ready;

    always_comb begin
        main_ctrl_d  = main_ctrl_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        state_d      = state_q;

        if (issue) begin
            if (skid_valid_q) begin
                main_ctrl_d  = skid_ctrl_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        // in_ready guarantees the skid is empty whenever an accept happens.
        if (accept) begin
            if (!main_valid_q || (issue && !skid_valid_q)) begin
                main_ctrl_d  = dec_ctrl;
                main_pc_d    = in_pc;
                main_valid_d = 1'b1;
            end else begin
                skid_ctrl_d  = dec_ctrl;
                skid_pc_d    = in_pc;
                skid_valid_d = 1'b1;
            end
        end

        case (state_q)
            StRun: begin
                if (accept && (dec_ctrl.alu_op == OpHalt)) state_d = StHalting;
            end
            StHalting: begin
                if (issue && (main_ctrl_q.alu_op == OpHalt)) state_d = StHalted;
            end
            default: ;
        endcase

        // Flush wins over everything except a completed halt.
        if (flush && (state_q != StHalted)) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = StRun;
        end

        in_ready_d = !skid_valid_d && (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q  <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            state_q      <= StRun;
        end else begin
            main_ctrl_q  <= main_ctrl_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            state_q      <= state_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign halted       = (state_q == StHalted);
    assign out_ALUOp    = main_ctrl_q.alu_op;
    assign out_ALUF     = main_ctrl_q.alu_f;
    assign out_rs       = main_ctrl_q.rs;
    assign out_rt       = main_ctrl_q.rt;
    assign out_rd       = main_ctrl_q.rd;
    assign out_regWrite = main_ctrl_q.reg_write;
    assign out_memRead  = main_ctrl_q.mem_read;
    assign out_memWrite = main_ctrl_q.mem_write;
    assign out_isBranch = main_ctrl_q.is_branch;
    assign out_isJump   = main_ctrl_q.is_jump;
    assign out_imm      = main_ctrl_q.imm;
    assign out_pc       = main_pc_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus random traffic
// checked against a queue-based reference model of the stage.
module tb_instr_decode_stage;

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  f;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic [15:0] imm;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [15:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_ALUOp;
    logic [1:0]  out_ALUF;
    logic [2:0]  out_rs, out_rt, out_rd;
    logic        out_regWrite, out_memRead, out_memWrite, out_isBranch, out_isJump;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: in-order queue of decoded bundles, state 0=run 1=halting 2=halted.
    exp_t mq[$];
    int   m_state = 0;
    logic m_rdy = 1'b0;

    instr_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ALUOp    (out_ALUOp),
        .out_ALUF     (out_ALUF),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_regWrite (out_regWrite),
        .out_memRead  (out_memRead),
        .out_memWrite (out_memWrite),
        .out_isBranch (out_isBranch),
        .out_isJump   (out_isJump),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        int   o;
        o = int'(ins[15:11]);
        e = '0;
        e.op = ins[15:11];
        e.f  = ins[1:0];
        e.rs = ins[10:8];
        e.rt = ins[7:5];
        e.pc = pc;
        if (o inside {26, 27, [28:31]})              e.rd = ins[4:2];
        else if (o inside {[8:11], [20:23], 17, 19}) e.rd = ins[7:5];
        else if (o inside {24, 18})                  e.rd = ins[10:8];
        else if (o inside {6, 7})                    e.rd = 3'd7;
        e.rw = (o inside {26, 27, [28:31], [8:11], [20:23], 17, 19, 24, 18, 25, 6, 7});
        e.mr = (o == 17);
        e.mw = (o == 16) || (o == 19);
        e.br = (o inside {[12:15]});
        e.jp = (o inside {[4:7]});
        if (o inside {10, 11, [20:23]})            e.imm = 16'(ins[4:0]);
        else if (o == 18)                          e.imm = 16'(ins[7:0]);
        else if (o inside {8, 9, 16, 17, 19})      e.imm = 16'($signed(ins[4:0]));
        else if (o inside {[12:15], 24, 5, 7})     e.imm = 16'($signed(ins[7:0]));
        else if (o inside {4, 6})                  e.imm = 16'($signed(ins[10:0]));
        return e;
    endfunction

    function automatic exp_t dut_bundle();
        exp_t g;
        g.op = out_ALUOp;    g.f  = out_ALUF;
        g.rs = out_rs;       g.rt = out_rt;       g.rd = out_rd;
        g.rw = out_regWrite; g.mr = out_memRead;  g.mw = out_memWrite;
        g.br = out_isBranch; g.jp = out_isJump;
        g.imm = out_imm;     g.pc = out_pc;
        return g;
    endfunction

    task automatic model_edge(input logic acc, input logic iss, input logic fl,
                              input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        if (fl && m_state != 2) begin
            mq.delete();
            m_state = 0;
        end else begin
            if (iss) begin
                e = mq.pop_front();
                if (m_state == 1 && e.op == 5'd0) m_state = 2;
            end
            if (acc) begin
                mq.push_back(ref_decode(ins, pc));
                if (ins[15:11] == 5'd0) m_state = 1;
            end
        end
        m_rdy = (mq.size() < 2) && (m_state == 0);
    endtask

    // One clock: drive at negedge, advance model at posedge, return at next negedge.
    task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic fl);
        logic acc, iss;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        acc = v && m_rdy;
        iss = (mq.size() > 0) && (m_state != 2) && ordy;
        @(posedge clk);
        model_edge(acc, iss, fl, ins, pc);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); m_state = 0; m_rdy = 1'b0;
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got v=%b h=%b r=%b want 0 0 0", out_valid, halted, in_ready);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_bundle() !== '0) begin
            n_errors++;
            $display("FAIL reset_datapath got %h want 0", dut_bundle());
        end
        rst_n = 1'b1;
        mq.delete(); m_state = 0; m_rdy = 1'b0;
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got r=%b v=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_stream();
        cyc(1'b1, 16'hD94C, 16'h0102, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_ALUOp !== 5'b11011 || out_ALUF !== 2'b00 ||
            out_rd !== 3'd3 || out_regWrite !== 1'b1 || out_pc !== 16'h0102) begin
            n_errors++;
            $display("FAIL add_stream got v=%b op=%b f=%b rd=%0d rw=%b pc=%h want 1 11011 00 3 1 0102",
                     out_valid, out_ALUOp, out_ALUF, out_rd, out_regWrite, out_pc);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        cyc(1'b1, 16'h4125, 16'h0010, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== 16'd5) begin
            n_errors++;
            $display("FAIL bp_first got v=%b r=%b imm=%h want 1 1 0005", out_valid, in_ready, out_imm);
        end
        cyc(1'b1, 16'h4226, 16'h0012, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full got in_ready=%b want 0", in_ready);
        end
        cyc(1'b1, 16'h4327, 16'h0014, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_imm !== 16'd5 || out_pc !== 16'h0010) begin
            n_errors++;
            $display("FAIL bp_hold got r=%b imm=%h pc=%h want 0 0005 0010", in_ready, out_imm, out_pc);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'd6 || out_pc !== 16'h0012 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second got v=%b imm=%h pc=%h r=%b want 1 0006 0012 1",
                     out_valid, out_imm, out_pc, in_ready);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_branch_nop();
        cyc(1'b1, 16'h61FC, 16'h0020, 1'b1, 1'b0);
        n_checks++;
        if (out_isBranch !== 1'b1 || out_imm !== 16'hFFFC || out_regWrite !== 1'b0) begin
            n_errors++;
            $display("FAIL beqz got br=%b imm=%h rw=%b want 1 fffc 0", out_isBranch, out_imm, out_regWrite);
        end
        cyc(1'b1, 16'h0800, 16'h0022, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_ALUOp !== 5'b00001 || out_regWrite !== 1'b0 ||
            out_memRead !== 1'b0 || out_memWrite !== 1'b0 || out_isBranch !== 1'b0 ||
            out_isJump !== 1'b0) begin
            n_errors++;
            $display("FAIL nop got v=%b op=%b ctl=%b%b%b%b%b want 1 00001 00000", out_valid, out_ALUOp,
                     out_regWrite, out_memRead, out_memWrite, out_isBranch, out_isJump);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_halt();
        cyc(1'b1, 16'h0000, 16'h0030, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_ALUOp !== 5'd0 || in_ready !== 1'b0 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_accept got v=%b op=%b r=%b h=%b want 1 00000 0 0",
                     out_valid, out_ALUOp, in_ready, halted);
        end
        cyc(1'b1, 16'h4125, 16'h0032, 1'b1, 1'b0);
        n_checks++;
        if (halted !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_issue got h=%b v=%b want 1 0", halted, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'h4125, 16'h0032, 1'b1, (i == 2));
            n_checks++;
            if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL halt_frozen cyc %0d got v=%b h=%b r=%b want 0 1 0",
                         i, out_valid, halted, in_ready);
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        cyc(1'b1, 16'hD94C, 16'h0040, 1'b0, 1'b0);
        cyc(1'b1, 16'h4125, 16'h0042, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_fill got r=%b v=%b want 0 1", in_ready, out_valid);
        end
        cyc(1'b1, 16'h4226, 16'h0044, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_full got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_empty got out_valid=%b want 0", out_valid);
        end
        cyc(1'b1, 16'h0000, 16'h0046, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_halting got v=%b r=%b h=%b want 0 1 0", out_valid, in_ready, halted);
        end
        cyc(1'b1, 16'h61FC, 16'h0048, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_isBranch !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_resume got v=%b br=%b want 1 1", out_valid, out_isBranch);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cyc(1'b1, 16'h4125, 16'h0050, 1'b0, 1'b0);
        cyc(1'b1, 16'h4226, 16'h0052, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async got v=%b r=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); m_state = 0; m_rdy = 1'b0;
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_release got v=%b h=%b r=%b want 0 0 1", out_valid, halted, in_ready);
        end
        cyc(1'b1, 16'h0800, 16'h0054, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0054) begin
            n_errors++;
            $display("FAIL reset_mid_run got v=%b pc=%h want 1 0054", out_valid, out_pc);
        end
    endtask

    task automatic test_random();
        logic        v, ordy, fl, exp_v;
        logic [15:0] ins, pc;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ins  = 16'($urandom);
            if (ins[15:11] == 5'd0) ins[15:11] = 5'd1;
            pc   = 16'($urandom);
            ordy = ($urandom_range(0, 1) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            cyc(v, ins, pc, ordy, fl);
            exp_v = (mq.size() > 0) && (m_state != 2);
            n_checks++;
            if (out_valid !== exp_v || in_ready !== m_rdy || halted !== (m_state == 2)) begin
                n_errors++;
                $display("FAIL rand_flags cyc %0d got v=%b r=%b h=%b want %b %b %b",
                         i, out_valid, in_ready, halted, exp_v, m_rdy, (m_state == 2));
            end
            if (exp_v) begin
                n_checks++;
                if (dut_bundle() !== mq[0]) begin
                    n_errors++;
                    $display("FAIL rand_bundle cyc %0d got %h want %h", i, dut_bundle(), mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_backpressure();
        test_branch_nop();
        test_halt();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
